// File: rtl/updi_link_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// updi_pkg
// Shared types and default sizing for the UPDI link sequencer:
//   updi_seq_state_t  - sequencer FSM states
//   updi_err_t        - transaction error classification (err_code encoding)
//   UPDI_*_DEFAULT    - default DATA_BITS / MAX_RX_BYTES / TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
package updi_pkg;

    localparam int UPDI_DATA_BITS_DEFAULT      = 8;
    localparam int UPDI_MAX_RX_BYTES_DEFAULT   = 16;
    localparam int UPDI_TIMEOUT_CYCLES_DEFAULT = 20000;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_ACCEPT = 3'd1,
        SEQ_LAUNCH = 3'd2,
        SEQ_ECHO   = 3'd3,
        SEQ_RESP   = 3'd4,
        SEQ_DONE   = 3'd5,
        SEQ_ERROR  = 3'd6,
        SEQ_FLUSH  = 3'd7
    } updi_seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ECHO    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_RX      = 2'd3
    } updi_err_t;

endpackage

// File: rtl/updi_link_sequencer_if.sv
// -----------------------------------------------------------------------------
// updi_link_sequencer_if
// Bundles every non-clock/reset signal of the UPDI link sequencer.
//   Requester side : cmd_data, cmd_valid, cmd_last, cmd_rx_len -> cmd_ready
//   UART tx side   : tx_data, tx_start -> ; tx_busy <-
//   UART rx side   : rx_data, rx_data_valid, rx_error <-
//   Link / status  : line_dir, rsp_data, rsp_valid, txn_done, txn_error, err_code
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding environment (requester + UART pair)
// -----------------------------------------------------------------------------
interface updi_link_sequencer_if
    import updi_pkg::*;
#(
    parameter int DATA_BITS    = UPDI_DATA_BITS_DEFAULT,
    parameter int MAX_RX_BYTES = UPDI_MAX_RX_BYTES_DEFAULT
);
    localparam int RLW = $clog2(MAX_RX_BYTES + 1);

    logic [DATA_BITS-1:0] cmd_data;
    logic                 cmd_valid;
    logic                 cmd_last;
    logic [RLW-1:0]       cmd_rx_len;
    logic                 cmd_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_data_valid;
    logic                 rx_error;
    logic                 line_dir;
    logic [DATA_BITS-1:0] rsp_data;
    logic                 rsp_valid;
    logic                 txn_done;
    logic                 txn_error;
    logic [1:0]           err_code;

    modport slave (
        input  cmd_data, cmd_valid, cmd_last, cmd_rx_len, tx_busy,
               rx_data, rx_data_valid, rx_error,
        output cmd_ready, tx_data, tx_start, line_dir, rsp_data, rsp_valid,
               txn_done, txn_error, err_code
    );

    modport master (
        output cmd_data, cmd_valid, cmd_last, cmd_rx_len, tx_busy,
               rx_data, rx_data_valid, rx_error,
        input  cmd_ready, tx_data, tx_start, line_dir, rsp_data, rsp_valid,
               txn_done, txn_error, err_code
    );

endinterface

// File: rtl/updi_link_sequencer_timeout_counter.sv
// -----------------------------------------------------------------------------
// timeout_counter
// Counts enabled clock cycles since the last clear. `expired` is a 1-clk
// strobe in the cycle whose increment brings the count to MAX, so a wait that
// has lasted MAX full cycles without a clear is flagged right at its end.
// The count saturates at MAX so the strobe cannot repeat without a clear.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - restart counting from zero (wins over en)
//   en        - count this cycle
//   expired   - 1-clk strobe, count reaching MAX
// -----------------------------------------------------------------------------
module timeout_counter #(
    parameter int MAX = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(MAX + 1);

    logic [TW-1:0] cnt_r;

    // Cycle counter: clear has priority, saturates at MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {TW{1'b0}};
        end else if (clr) begin
            cnt_r <= {TW{1'b0}};
        end else if (en && (cnt_r != TW'(MAX))) begin
            cnt_r <= cnt_r + TW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = en && !clr && (cnt_r == TW'(MAX - 1));

endmodule

// File: rtl/updi_link_sequencer.sv
// -----------------------------------------------------------------------------
// updi_link_sequencer
// Sequences the half-duplex single-wire UPDI link: takes command bytes from the
// instruction layer, launches each one on uart_tx, consumes its pin echo from
// uart_rx, then releases the pin and collects the requested number of response
// bytes. Each transaction ends with a txn_done or a classified txn_error.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   bus (slave)   - updi_link_sequencer_if: command handshake, uart tx/rx,
//                   line_dir, response stream and status (see interface)
// Build option:
//   UPDI_ECHO_CHECK_EN - when defined, each echo byte is compared with the
//                        transmitted byte and a mismatch reports err_code 1.
//                        When undefined the echo is only counted.
// All outputs are registered.
// -----------------------------------------------------------------------------
module updi_link_sequencer
    import updi_pkg::*;
#(
    parameter int DATA_BITS      = UPDI_DATA_BITS_DEFAULT,
    parameter int MAX_RX_BYTES   = UPDI_MAX_RX_BYTES_DEFAULT,
    parameter int TIMEOUT_CYCLES = UPDI_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    updi_link_sequencer_if.slave   bus
);
    localparam int RLW = $clog2(MAX_RX_BYTES + 1);

    updi_seq_state_t       state_r;
    logic                  cmd_ready_r;
    logic [DATA_BITS-1:0]  tx_data_r;
    logic                  tx_start_r;
    logic                  line_dir_r;
    logic [DATA_BITS-1:0]  rsp_data_r;
    logic                  rsp_valid_r;
    logic                  txn_done_r;
    logic                  txn_error_r;
    updi_err_t             err_code_r;
    logic                  last_r;
    logic [RLW-1:0]        rx_len_r;

    logic                  tmo_en_s;
    logic                  tmo_clr_s;
    logic                  tmo_expired_s;
    logic                  fault_s;
    updi_err_t             fault_code_s;
    logic                  byte_ok_s;
    logic                  cmd_hs_s;

    // Requested response lengths beyond the buffer limit are clipped.
    function automatic logic [RLW-1:0] sat_len(input logic [RLW-1:0] len);
        if (len > RLW'(MAX_RX_BYTES)) begin
            sat_len = RLW'(MAX_RX_BYTES);
        end else begin
            sat_len = len;
        end
    endfunction

    // The receiver is only timed while a byte is actually owed to us; any
    // receiver event restarts the wait.
    assign tmo_en_s  = (state_r == SEQ_ECHO) || (state_r == SEQ_RESP);
    assign tmo_clr_s = !tmo_en_s || bus.rx_data_valid || bus.rx_error;
    assign cmd_hs_s  = cmd_ready_r && bus.cmd_valid;

    timeout_counter #(
        .MAX     (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr_s),
        .en      (tmo_en_s),
        .expired (tmo_expired_s)
    );

    // Receiver event decode: rx_error beats a byte, a byte beats the timeout.
    always_comb begin
        fault_s      = 1'b0;
        fault_code_s = ERR_NONE;
        byte_ok_s    = 1'b0;
        if (bus.rx_error) begin
            fault_s      = 1'b1;
            fault_code_s = ERR_RX;
        end else if (bus.rx_data_valid) begin
`ifdef UPDI_ECHO_CHECK_EN
            if ((state_r == SEQ_ECHO) && (bus.rx_data != tx_data_r)) begin
                fault_s      = 1'b1;
                fault_code_s = ERR_ECHO;
            end else begin
                byte_ok_s = 1'b1;
            end
`else
            byte_ok_s = 1'b1;
`endif
        end else if (tmo_expired_s) begin
            fault_s      = 1'b1;
            fault_code_s = ERR_TIMEOUT;
        end else begin
            fault_s      = 1'b0;
            fault_code_s = ERR_NONE;
            byte_ok_s    = 1'b0;
        end
    end

    // Sequencer FSM with registered outputs; pulse outputs default low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SEQ_IDLE;
            cmd_ready_r <= 1'b0;
            tx_data_r   <= {DATA_BITS{1'b0}};
            tx_start_r  <= 1'b0;
            line_dir_r  <= 1'b0;
            rsp_data_r  <= {DATA_BITS{1'b0}};
            rsp_valid_r <= 1'b0;
            txn_done_r  <= 1'b0;
            txn_error_r <= 1'b0;
            err_code_r  <= ERR_NONE;
            last_r      <= 1'b0;
            rx_len_r    <= {RLW{1'b0}};
        end else begin
            tx_start_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
            txn_done_r  <= 1'b0;
            txn_error_r <= 1'b0;
            case (state_r)
                SEQ_IDLE, SEQ_ACCEPT: begin
                    if (cmd_hs_s) begin
                        tx_data_r   <= bus.cmd_data;
                        line_dir_r  <= 1'b1;
                        err_code_r  <= ERR_NONE;
                        last_r      <= bus.cmd_last;
                        if (bus.cmd_last) begin
                            rx_len_r <= sat_len(bus.cmd_rx_len);
                        end
                        cmd_ready_r <= 1'b0;
                        state_r     <= SEQ_LAUNCH;
                    end else begin
                        // First cycle out of reset arrives here with ready low.
                        cmd_ready_r <= 1'b1;
                    end
                end
                SEQ_LAUNCH: begin
                    if (!bus.tx_busy) begin
                        tx_start_r <= 1'b1;
                        state_r    <= SEQ_ECHO;
                    end
                end
                SEQ_ECHO: begin
                    if (fault_s) begin
                        line_dir_r  <= 1'b0;
                        err_code_r  <= fault_code_s;
                        txn_error_r <= 1'b1;
                        state_r     <= SEQ_ERROR;
                    end else if (byte_ok_s) begin
                        if (!last_r) begin
                            cmd_ready_r <= 1'b1;
                            state_r     <= SEQ_ACCEPT;
                        end else begin
                            // Whole command is on the wire: hand the pin over.
                            line_dir_r <= 1'b0;
                            if (rx_len_r != {RLW{1'b0}}) begin
                                state_r <= SEQ_RESP;
                            end else begin
                                txn_done_r <= 1'b1;
                                state_r    <= SEQ_DONE;
                            end
                        end
                    end
                end
                SEQ_RESP: begin
                    if (fault_s) begin
                        line_dir_r  <= 1'b0;
                        err_code_r  <= fault_code_s;
                        txn_error_r <= 1'b1;
                        state_r     <= SEQ_ERROR;
                    end else if (byte_ok_s) begin
                        rsp_data_r  <= bus.rx_data;
                        rsp_valid_r <= 1'b1;
                        rx_len_r    <= rx_len_r - RLW'(1);
                        if (rx_len_r == RLW'(1)) begin
                            txn_done_r <= 1'b1;
                            state_r    <= SEQ_DONE;
                        end
                    end
                end
                SEQ_DONE: begin
                    cmd_ready_r <= 1'b1;
                    state_r     <= SEQ_IDLE;
                end
                SEQ_ERROR: begin
                    // Unsent tail of the command must still be drained.
                    cmd_ready_r <= 1'b1;
                    state_r     <= last_r ? SEQ_IDLE : SEQ_FLUSH;
                end
                SEQ_FLUSH: begin
                    cmd_ready_r <= 1'b1;
                    if (cmd_hs_s && bus.cmd_last) begin
                        state_r <= SEQ_IDLE;
                    end
                end
                default: begin
                    cmd_ready_r <= 1'b0;
                    line_dir_r  <= 1'b0;
                    state_r     <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_start  = tx_start_r;
    assign bus.line_dir  = line_dir_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.txn_done  = txn_done_r;
    assign bus.txn_error = txn_error_r;
    assign bus.err_code  = err_code_r;

endmodule

// File: tb/tb_updi_link_sequencer.sv
// -----------------------------------------------------------------------------
// tb_updi_link_sequencer
// Directed bench for updi_link_sequencer (TIMEOUT_CYCLES = 50). Stimulus pushes
// the expected output events (tx launch, response byte, done, error) into a
// queue; a monitor on the falling edge pops and compares one entry for every
// event the DUT presents. Timing-specific properties are checked inline.
// -----------------------------------------------------------------------------
module tb_updi_link_sequencer;

    localparam logic [3:0] EV_TX   = 4'd1;
    localparam logic [3:0] EV_RSP  = 4'd2;
    localparam logic [3:0] EV_DONE = 4'd3;
    localparam logic [3:0] EV_ERR  = 4'd4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   tx_cnt;
    int   tx_before;
    logic [15:0] exp_q[$];

    updi_link_sequencer_if #(.DATA_BITS(8), .MAX_RX_BYTES(16)) bus ();

    updi_link_sequencer #(
        .DATA_BITS      (8),
        .MAX_RX_BYTES   (16),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_ev(input logic [3:0] k, input logic [7:0] d, input logic [1:0] c);
        exp_q.push_back({k, 2'b00, c, d});
    endfunction

    task automatic pop_check(input string name, input logic [15:0] act);
        logic [15:0] exp;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got unexpected event 0x%0h, expected no event", name, act);
        end else begin
            exp = exp_q.pop_front();
            check(name, {16'h0000, act}, {16'h0000, exp});
        end
    endtask

    // Monitor: every output event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bus.tx_start) begin
            tx_cnt++;
            pop_check("ev_tx_start", {EV_TX, 4'h0, bus.tx_data});
        end
        if (bus.rsp_valid) begin
            pop_check("ev_rsp", {EV_RSP, 4'h0, bus.rsp_data});
        end
        if (bus.txn_done) begin
            pop_check("ev_done", {EV_DONE, 4'h0, 8'h00});
        end
        if (bus.txn_error) begin
            pop_check("ev_error", {EV_ERR, 2'b00, bus.err_code, 8'h00});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on a falling edge after the handshake.
    task automatic send_cmd(input logic [7:0] d, input logic last, input logic [4:0] len);
        int i;
        bus.cmd_data   = d;
        bus.cmd_last   = last;
        bus.cmd_rx_len = len;
        bus.cmd_valid  = 1'b1;
        i = 0;
        while (!bus.cmd_ready && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_last  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx(input string name);
        int i;
        i = 0;
        while (!bus.tx_start && i < 100) begin
            @(negedge clk);
            i++;
        end
        check({name, "_tx_seen"}, {31'd0, bus.tx_start}, 32'd1);
    endtask

    // One-cycle receiver strobe; returns on the following falling edge.
    task automatic rx_pulse(input logic [7:0] d, input logic err);
        bus.rx_data       = d;
        bus.rx_data_valid = 1'b1;
        bus.rx_error      = err;
        @(negedge clk);
        bus.rx_data_valid = 1'b0;
        bus.rx_error      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected completion before 100us");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0; tx_cnt = 0; tx_before = 0;
        rst = 1'b1;
        bus.cmd_data = 8'h00; bus.cmd_valid = 1'b0; bus.cmd_last = 1'b0;
        bus.cmd_rx_len = 5'd0; bus.tx_busy = 1'b0; bus.rx_data = 8'h00;
        bus.rx_data_valid = 1'b0; bus.rx_error = 1'b0;

        // Reset state: every output low.
        idle(3);
        check("reset_outputs", {8'h00, bus.cmd_ready, bus.tx_start, bus.line_dir, bus.rsp_valid,
              bus.txn_done, bus.txn_error, bus.err_code, bus.tx_data, bus.rsp_data}, 32'd0);
        rst = 1'b0;
        idle(2);
        check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // 2-byte command 55,C4 with one reply byte; second launch stalled by tx_busy.
        push_ev(EV_TX, 8'h55, 2'd0);
        send_cmd(8'h55, 1'b0, 5'd0);
        wait_tx("t1_b0");
        check("t1_line_dir_driven", {31'd0, bus.line_dir}, 32'd1);
        idle(3);
        rx_pulse(8'h55, 1'b0);
        bus.tx_busy = 1'b1;
        push_ev(EV_TX, 8'hC4, 2'd0);
        send_cmd(8'hC4, 1'b1, 5'd1);
        tx_before = tx_cnt;
        idle(4);
        check("t1_launch_stall", tx_cnt, tx_before);
        bus.tx_busy = 1'b0;
        wait_tx("t1_b1");
        idle(3);
        check("t1_line_dir_before_echo", {31'd0, bus.line_dir}, 32'd1);
        rx_pulse(8'hC4, 1'b0);
        check("t1_line_dir_released", {31'd0, bus.line_dir}, 32'd0);
        idle(2);
        push_ev(EV_RSP, 8'h30, 2'd0);
        push_ev(EV_DONE, 8'h00, 2'd0);
        rx_pulse(8'h30, 1'b0);
        check("t1_done", {31'd0, bus.txn_done}, 32'd1);
        idle(3);

        // Single byte, no response: done one cycle after the echo.
        push_ev(EV_TX, 8'h55, 2'd0);
        send_cmd(8'h55, 1'b1, 5'd0);
        wait_tx("t2");
        idle(2);
        push_ev(EV_DONE, 8'h00, 2'd0);
        rx_pulse(8'h55, 1'b0);
        check("t2_done_latency", {31'd0, bus.txn_done}, 32'd1);
        idle(3);

        // A5 transmitted, A4 echoed, two more command bytes follow.
        push_ev(EV_TX, 8'hA5, 2'd0);
        send_cmd(8'hA5, 1'b0, 5'd0);
        wait_tx("t3_b0");
        idle(2);
`ifdef UPDI_ECHO_CHECK_EN
        push_ev(EV_ERR, 8'h00, 2'd1);
        rx_pulse(8'hA4, 1'b0);
        check("t3_echo_err", {29'd0, bus.txn_error, bus.err_code}, {29'd0, 1'b1, 2'd1});
        check("t3_line_dir", {31'd0, bus.line_dir}, 32'd0);
        tx_before = tx_cnt;
        send_cmd(8'h11, 1'b0, 5'd0);
        send_cmd(8'h22, 1'b1, 5'd0);
        idle(4);
        check("t3_flush_no_tx", tx_cnt, tx_before);
        check("t3_ready_after_flush", {31'd0, bus.cmd_ready}, 32'd1);
`else
        rx_pulse(8'hA4, 1'b0);
        push_ev(EV_TX, 8'h11, 2'd0);
        send_cmd(8'h11, 1'b0, 5'd0);
        wait_tx("t3_b1");
        idle(2);
        rx_pulse(8'h11, 1'b0);
        push_ev(EV_TX, 8'h22, 2'd0);
        send_cmd(8'h22, 1'b1, 5'd0);
        wait_tx("t3_b2");
        idle(2);
        push_ev(EV_DONE, 8'h00, 2'd0);
        rx_pulse(8'h22, 1'b0);
        check("t3_done", {31'd0, bus.txn_done}, 32'd1);
`endif
        idle(3);

        // rx_len=2 but only one reply byte: timeout 50 cycles after it.
        push_ev(EV_TX, 8'h24, 2'd0);
        send_cmd(8'h24, 1'b1, 5'd2);
        wait_tx("t4");
        idle(2);
        rx_pulse(8'h24, 1'b0);
        idle(2);
        push_ev(EV_RSP, 8'h5A, 2'd0);
        push_ev(EV_ERR, 8'h00, 2'd2);
        rx_pulse(8'h5A, 1'b0);
        idle(49);
        check("t4_timeout_not_early", {31'd0, bus.txn_error}, 32'd0);
        idle(1);
        check("t4_timeout_at_50", {29'd0, bus.txn_error, bus.err_code}, {29'd0, 1'b1, 2'd2});
        check("t4_line_dir", {31'd0, bus.line_dir}, 32'd0);
        idle(3);

        // rx_error coincident with rx_data_valid during the response window.
        push_ev(EV_TX, 8'h33, 2'd0);
        send_cmd(8'h33, 1'b1, 5'd2);
        wait_tx("t5");
        idle(2);
        rx_pulse(8'h33, 1'b0);
        push_ev(EV_RSP, 8'h10, 2'd0);
        rx_pulse(8'h10, 1'b0);
        push_ev(EV_ERR, 8'h00, 2'd3);
        rx_pulse(8'h99, 1'b1);
        check("t5_rx_err", {28'd0, bus.rsp_valid, bus.txn_error, bus.err_code}, {28'd0, 1'b0, 1'b1, 2'd3});
        idle(3);

        // Oversized rx_len (20) is clipped to 16 response bytes.
        push_ev(EV_TX, 8'h40, 2'd0);
        send_cmd(8'h40, 1'b1, 5'd20);
        wait_tx("t7");
        idle(2);
        rx_pulse(8'h40, 1'b0);
        for (int i = 0; i < 16; i++) begin
            push_ev(EV_RSP, 8'h80 + 8'(i), 2'd0);
            if (i == 15) begin
                push_ev(EV_DONE, 8'h00, 2'd0);
            end
            rx_pulse(8'h80 + 8'(i), 1'b0);
            idle(1);
        end
        idle(3);

        // Reset while waiting for the echo: silent abort.
        push_ev(EV_TX, 8'h66, 2'd0);
        send_cmd(8'h66, 1'b1, 5'd0);
        wait_tx("t6");
        idle(2);
        rst = 1'b1;
        idle(1);
        check("t6_reset_outputs", {8'h00, bus.cmd_ready, bus.tx_start, bus.line_dir, bus.rsp_valid,
              bus.txn_done, bus.txn_error, bus.err_code, bus.tx_data, bus.rsp_data}, 32'd0);
        idle(1);
        rst = 1'b0;
        idle(3);
        check("t6_ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);
        rx_pulse(8'h66, 1'b0);
        idle(5);
        check("t6_stray_rx_ignored", {30'd0, bus.txn_done, bus.line_dir}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
